// File: rtl/instruction_fetch_stage_pkg.sv
// Shared definitions for the IF stage: reserved instruction words, FSM states,
// next-PC select codes and the IF/ID register layout.
package instruction_fetch_stage_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 32;

    localparam logic [PC_W-1:0]    DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [INSTR_W-1:0] DEFAULT_NOP_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        PC_SEL_SEQ    = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JUMP   = 2'd2
    } pc_sel_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc_plus4;
        logic               valid;
    } if_id_t;

    // Redirect targets are byte addresses; fetch is always word aligned.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/instruction_fetch_stage_pc_register.sv
// Program counter with synchronous reset, load enable and a next-PC mux
// selecting sequential, branch or jump targets.
module pc_register
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_en_i,
    input  pc_sel_e         sel_i,
    input  logic [PC_W-1:0] branch_target_i,
    input  logic [PC_W-1:0] jump_target_i,
    output logic [PC_W-1:0] pc_o
);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en_i) begin
            unique case (sel_i)
                PC_SEL_BRANCH: pc_d = word_align(branch_target_i);
                PC_SEL_JUMP:   pc_d = word_align(jump_target_i);
                default:       pc_d = pc_q + 32'd4;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: owns the PC, fetches from a zero-latency instruction memory and
// fills the IF/ID register, honouring stall, flush, redirect and halt.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0]    RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD,
    parameter logic [INSTR_W-1:0] NOP_WORD  = DEFAULT_NOP_WORD
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Stall,
    input  logic               Flush,
    input  logic               BranchTaken,
    input  logic [PC_W-1:0]    BranchTarget,
    input  logic               Jump,
    input  logic [PC_W-1:0]    JumpTarget,
    input  logic [INSTR_W-1:0] Instruction,
    output logic [PC_W-1:0]    PCAddress,
    output logic [INSTR_W-1:0] IF_ID_Instruction,
    output logic [PC_W-1:0]    IF_ID_PCPlus4,
    output logic               IF_ID_Valid,
    output logic               Halted,
    output logic [31:0]        FetchCount,
    output logic [1:0]         FsmState
);

    localparam if_id_t BUBBLE = '{instr: NOP_WORD, pc_plus4: '0, valid: 1'b0};

    fetch_state_e    state_q, state_d;
    if_id_t          if_id_q, if_id_d;
    logic [31:0]     count_q, count_d;
    logic            pc_load;
    pc_sel_e         pc_sel;
    logic            redirect;
    logic [PC_W-1:0] pc_plus4;

    pc_register #(.RESET_PC(RESET_PC)) u_pc (
        .clk_i           (Clk),
        .reset_i         (Reset),
        .load_en_i       (pc_load),
        .sel_i           (pc_sel),
        .branch_target_i (BranchTarget),
        .jump_target_i   (JumpTarget),
        .pc_o            (PCAddress)
    );

    assign pc_plus4 = PCAddress + 32'd4;
    assign redirect = Jump | BranchTaken;

    always_comb begin
        state_d = state_q;
        if_id_d = if_id_q;
        count_d = count_q;
        pc_load = 1'b0;
        pc_sel  = Jump ? PC_SEL_JUMP : (BranchTaken ? PC_SEL_BRANCH : PC_SEL_SEQ);
        unique case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if_id_d = BUBBLE;
            end
            ST_RUN: begin
                if (redirect) begin
                    pc_load = 1'b1;
                    if_id_d = BUBBLE;
                end else if (Stall) begin
                    if_id_d = if_id_q;
                end else if (Flush) begin
                    pc_load = 1'b1;
                    if_id_d = BUBBLE;
                end else if (Instruction == HALT_WORD) begin
                    // PC stays on the halt word so it remains visible while halted.
                    state_d = ST_HALT;
                    if_id_d = BUBBLE;
                end else begin
                    pc_load = 1'b1;
                    if_id_d = '{instr: Instruction, pc_plus4: pc_plus4, valid: 1'b1};
                    count_d = count_q + 32'd1;
                end
            end
            ST_HALT: begin
                if_id_d = BUBBLE;
                if (redirect) begin
                    pc_load = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_BOOT;
                if_id_d = BUBBLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_BOOT;
            if_id_q <= BUBBLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if_id_q <= if_id_d;
            count_q <= count_d;
        end
    end

    assign IF_ID_Instruction = if_id_q.instr;
    assign IF_ID_PCPlus4     = if_id_q.pc_plus4;
    assign IF_ID_Valid       = if_id_q.valid;
    assign Halted            = (state_q == ST_HALT);
    assign FetchCount        = count_q;
    assign FsmState          = state_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: directed scenarios with literal expectations
// followed by randomized traffic, all outputs compared against a behavioural model.
module tb_instruction_fetch_stage;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  // Clock / reset / stimulus signals
  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, BranchTaken, Jump;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] Instruction;
  logic [31:0] PCAddress, IF_ID_Instruction, IF_ID_PCPlus4, FetchCount;
  logic        IF_ID_Valid, Halted;
  logic [1:0]  FsmState;

  logic [31:0] mem [128];

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  assign Instruction = mem[PCAddress[8:2]];

  instruction_fetch_stage dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Stall             (Stall),
    .Flush             (Flush),
    .BranchTaken       (BranchTaken),
    .BranchTarget      (BranchTarget),
    .Jump              (Jump),
    .JumpTarget        (JumpTarget),
    .Instruction       (Instruction),
    .PCAddress         (PCAddress),
    .IF_ID_Instruction (IF_ID_Instruction),
    .IF_ID_PCPlus4     (IF_ID_PCPlus4),
    .IF_ID_Valid       (IF_ID_Valid),
    .Halted            (Halted),
    .FetchCount        (FetchCount),
    .FsmState          (FsmState)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state as plain flags, updated from the rules at each edge
  bit          m_ready = 0;
  bit          m_boot, m_halted;
  logic [31:0] m_pc, m_instr, m_pc4, m_count;
  bit          m_valid;

  task automatic m_bubble();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 0;
  endtask

  always @(posedge Clk) begin
    logic [31:0] word;
    word = mem[m_pc[8:2]];
    if (Reset) begin
      m_ready = 1; m_boot = 1; m_halted = 0;
      m_pc = 32'h0; m_count = 32'h0;
      m_bubble();
    end else if (m_ready) begin
      if (m_boot) begin
        m_boot = 0;
        m_bubble();
      end else if (Jump || BranchTaken) begin
        m_pc = (Jump ? JumpTarget : BranchTarget) & 32'hFFFF_FFFC;
        m_halted = 0;
        m_bubble();
      end else if (m_halted) begin
        m_bubble();
      end else if (Stall) begin
        // hold everything
      end else if (Flush) begin
        m_pc = m_pc + 32'd4;
        m_bubble();
      end else if (word == HALT) begin
        m_halted = 1;
        m_bubble();
      end else begin
        m_instr = word;
        m_pc    = m_pc + 32'd4;
        m_pc4   = m_pc;
        m_valid = 1;
        m_count = m_count + 32'd1;
      end
    end
  end

  // Scoreboard: compare every output against the model each cycle
  always @(negedge Clk) begin
    if (m_ready) begin
      check("pc",     PCAddress,          m_pc);
      check("instr",  IF_ID_Instruction,  m_instr);
      check("pc4",    IF_ID_PCPlus4,      m_pc4);
      check("valid",  {31'b0, IF_ID_Valid}, {31'b0, m_valid});
      check("halted", {31'b0, Halted},    {31'b0, m_halted});
      check("count",  FetchCount,         m_count);
      check("state",  {30'b0, FsmState},  m_boot ? 32'd0 : (m_halted ? 32'd2 : 32'd1));
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Reset = 0; Stall = 0; Flush = 0; BranchTaken = 0; Jump = 0;
    BranchTarget = 32'h0; JumpTarget = 32'h0;
  endtask

  task automatic expect_ifid(input string tag, input logic [31:0] ins, input logic [31:0] p4);
    check({tag, "_instr"}, IF_ID_Instruction, ins);
    check({tag, "_pc4"},   IF_ID_PCPlus4, p4);
    check({tag, "_valid"}, {31'b0, IF_ID_Valid}, 32'd1);
    check({tag, "_model"}, m_instr, ins);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = i * 3;
    clear_inputs();

    // Reset and boot
    Reset = 1;
    step(); step();
    Reset = 0;
    check("boot_pc", PCAddress, 32'h0);
    check("boot_valid", {31'b0, IF_ID_Valid}, 32'd0);
    step();
    check("after_boot_pc", PCAddress, 32'h0);
    step();
    expect_ifid("first", 32'd0, 32'd4);
    step();
    expect_ifid("second", 32'd3, 32'd8);
    check("second_pc", PCAddress, 32'h8);

    // Stall holds PC, IF/ID and count
    Stall = 1;
    repeat (3) begin
      step();
      check("stall_pc", PCAddress, 32'h8);
      check("stall_instr", IF_ID_Instruction, 32'd3);
      check("stall_pc4", IF_ID_PCPlus4, 32'd8);
      check("stall_count", FetchCount, 32'd2);
    end
    Stall = 0;
    step();
    expect_ifid("post_stall", 32'd6, 32'd12);

    // Branch overrides stall, target aligned
    BranchTaken = 1; BranchTarget = 32'h42; Stall = 1;
    step();
    check("br_pc", PCAddress, 32'h40);
    check("br_valid", {31'b0, IF_ID_Valid}, 32'd0);
    clear_inputs();
    step();
    expect_ifid("br_next", 32'd48, 32'h44);

    // Jump wins over branch
    Jump = 1; JumpTarget = 32'h10; BranchTaken = 1; BranchTarget = 32'h20;
    step();
    check("jmp_pc", PCAddress, 32'h10);
    clear_inputs();
    step();
    check("jmp_instr", IF_ID_Instruction, 32'd12);

    // Flush alone at PC 0x8
    Jump = 1; JumpTarget = 32'h8;
    step();
    clear_inputs();
    Flush = 1;
    step();
    check("fl_pc", PCAddress, 32'hC);
    check("fl_valid", {31'b0, IF_ID_Valid}, 32'd0);
    clear_inputs();
    step();
    expect_ifid("fl_next", 32'd9, 32'h10);

    // PC+4 wraps modulo 2^32
    Jump = 1; JumpTarget = 32'hFFFF_FFFE;
    step();
    check("wrap_pc_top", PCAddress, 32'hFFFF_FFFC);
    clear_inputs();
    step();
    check("wrap_pc", PCAddress, 32'h0);
    expect_ifid("wrap", 32'd381, 32'h0);

    // Halt word stops fetch
    mem[5] = HALT;
    Reset = 1;
    step();
    Reset = 0;
    check("rst_count", FetchCount, 32'd0);
    step();
    repeat (5) step();
    check("pre_halt_count", FetchCount, 32'd5);
    step();
    check("halt_flag", {31'b0, Halted}, 32'd1);
    check("halt_pc", PCAddress, 32'h14);
    check("halt_valid", {31'b0, IF_ID_Valid}, 32'd0);
    check("halt_count", FetchCount, 32'd5);
    step(); step();
    check("halt_hold_pc", PCAddress, 32'h14);
    Jump = 1; JumpTarget = 32'h0;
    step();
    clear_inputs();
    check("unhalt_flag", {31'b0, Halted}, 32'd0);
    check("unhalt_pc", PCAddress, 32'h0);

    // Reset while halted
    repeat (6) step();
    check("rehalt_flag", {31'b0, Halted}, 32'd1);
    check("rehalt_count", FetchCount, 32'd10);
    Reset = 1; Stall = 1;
    step();
    clear_inputs();
    check("rst_halt_pc", PCAddress, 32'h0);
    check("rst_halt_flag", {31'b0, Halted}, 32'd0);
    check("rst_halt_count", FetchCount, 32'd0);

    // Reset while stalled
    step(); step(); step();
    Stall = 1;
    step();
    Reset = 1;
    step();
    clear_inputs();
    check("rst_stall_pc", PCAddress, 32'h0);
    check("rst_stall_valid", {31'b0, IF_ID_Valid}, 32'd0);
    check("rst_stall_count", FetchCount, 32'd0);
    mem[5] = 32'd15;

    // Randomized traffic against the model
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 500 == 0) begin
        for (int i = 0; i < 128; i++)
          mem[i] = ($urandom_range(0, 99) < 4) ? HALT : $urandom;
      end
      Reset        = ($urandom_range(0, 199) == 0);
      Jump         = ($urandom_range(0, 99) < 4);
      BranchTaken  = ($urandom_range(0, 99) < 5);
      Stall        = ($urandom_range(0, 99) < 15);
      Flush        = ($urandom_range(0, 99) < 8);
      JumpTarget   = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 511));
      BranchTarget = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 511));
      step();
    end
    clear_inputs();
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
